// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the dff_bank_arbiter block.
// Holds the FSM state encoding, the default sizing parameters and a
// constant clog2 helper. The helper sizes the owner index and the hold
// counter.
package dff_bank_arbiter_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_REVOKE = 2'd2
    } state_t;

    // Number of bits needed to hold the values 0..n-1 (minimum 1).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// Handshake: a requester holds req[i] high for the whole time it wants the
// register. It may write (wr[i] plus its din slice) only in cycles where
// gnt[i] is high. Ownership ends when it drops req[i] or when the arbiter
// pulses timeout. The arbiter never drives gnt to more than one requester.
//   req, wr  : per-requester request and write strobe (master -> slave)
//   din      : flattened write data, slice i = din[i*DW +: DW]
//   gnt      : registered one-hot grant (slave -> master)
//   q        : shared register contents
//   owner    : index of the current or last owner
//   busy     : high while a grant is held
//   timeout  : one-cycle pulse when the watchdog revokes a grant
//   state    : debug view of the arbiter FSM
interface dff_bank_arbiter_if
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW
) ();
    localparam int IW = clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    wr;
    logic [N_REQ*DW-1:0] din;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       q;
    logic [IW-1:0]       owner;
    logic                busy;
    logic                timeout;
    state_t              state;

    modport master (
        output req, wr, din,
        input  gnt, q, owner, busy, timeout, state
    );

    modport slave (
        input  req, wr, din,
        output gnt, q, owner, busy, timeout, state
    );
endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin priority select.
// Scans the requesters starting at (last+1) mod N_REQ and wrapping round.
// It returns the first requester that has its request set.
//   req   : request vector
//   last  : index that had the grant most recently (lowest priority now)
//   pick  : selected index (0 when valid is low)
//   valid : at least one request is set
module dff_bank_arbiter_rr_pick
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    pick,
    output logic             valid
);
    int idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        // Offset N_REQ wraps back to last itself, so a lone requester is re-picked.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                pick  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one DW-bit D register
// among N_REQ requesters.
// The owner keeps the grant until it drops req or until the hold watchdog
// revokes it after TIMEOUT cycles.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dff_bank_arbiter_if.slave (req/wr/din in, gnt/q/owner/busy/timeout/state out)
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    dff_bank_arbiter_if.slave  bus
);
    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(TIMEOUT);
    localparam logic [CW-1:0] HOLD_MAX = CW'(TIMEOUT - 1);

    state_t           state;
    logic [N_REQ-1:0] gnt_r;
    logic [DW-1:0]    q_r;
    logic [IW-1:0]    owner_r;
    logic [IW-1:0]    last;
    logic [CW-1:0]    hold_cnt;
    logic             busy_r;
    logic             timeout_r;
    logic [IW-1:0]    pick;
    logic             pick_valid;

    dff_bank_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req   (bus.req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_r     <= '0;
            q_r       <= '0;
            owner_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            hold_cnt  <= '0;
            // Requester 0 scans first after reset.
            last      <= IW'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout_r <= 1'b0;
                    if (pick_valid) begin
                        gnt_r    <= N_REQ'(1) << pick;
                        owner_r  <= pick;
                        busy_r   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_OWN;
                    end else begin
                        gnt_r <= '0;
                    end
                end
                ST_OWN: begin
                    timeout_r <= 1'b0;
                    // The D-register row: only the owner's strobe loads it.
                    // A write on the release or revoke edge still lands.
                    if (bus.wr[owner_r]) begin
                        q_r <= bus.din[owner_r*DW +: DW];
                    end
                    if (!bus.req[owner_r]) begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                        last   <= owner_r;
                        state  <= ST_IDLE;
                    end else if (hold_cnt == HOLD_MAX) begin
                        gnt_r     <= '0;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        last      <= owner_r;
                        state     <= ST_REVOKE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_REVOKE: begin
                    timeout_r <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.q       = q_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;
    assign bus.state   = state;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (N_REQ=4, DW=8, TIMEOUT=15).
// A vector table covers grant, write, ignored writes and release. Hand-written
// sequences cover reset, round-robin order, the watchdog and fairness.
module tb_dff_bank_arbiter;
    import dff_bank_arbiter_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dff_bank_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    dff_bank_arbiter #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d);
        bus.req = r;
        bus.wr  = w;
        bus.din = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
        logic        tmo;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int exp_gnt;
        int run;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0);

        //            rst   req      wr       din            gnt      q      own   busy  tmo
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0};
        // req[2] alone: granted one edge later (scan 0,1,2).
        vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 32'h00000000, 4'b0100, 8'h00, 2'd2, 1'b1, 1'b0};
        // Owner 2 writes 3C while non-owner 0 writes FF: only 3C lands.
        vecs[2]  = '{1'b0, 4'b0100, 4'b0101, 32'h003C00FF, 4'b0100, 8'h3C, 2'd2, 1'b1, 1'b0};
        // Non-owner write alone is ignored.
        vecs[3]  = '{1'b0, 4'b0100, 4'b0001, 32'h00000011, 4'b0100, 8'h3C, 2'd2, 1'b1, 1'b0};
        // Release with a write on the same edge: write honoured.
        vecs[4]  = '{1'b0, 4'b0000, 4'b0100, 32'h00770000, 4'b0000, 8'h77, 2'd2, 1'b0, 1'b0};
        // last=2: scan 3 first.
        vecs[5]  = '{1'b0, 4'b1001, 4'b0000, 32'h00000000, 4'b1000, 8'h77, 2'd3, 1'b1, 1'b0};
        // Owner 3 drops req with wr[3] and 5A.
        vecs[6]  = '{1'b0, 4'b0001, 4'b1000, 32'h5A000000, 4'b0000, 8'h5A, 2'd3, 1'b0, 1'b0};
        // last=3: arbitration restarts from requester 0.
        vecs[7]  = '{1'b0, 4'b0011, 4'b0000, 32'h00000000, 4'b0001, 8'h5A, 2'd0, 1'b1, 1'b0};
        // Non-owner req changes have no effect during OWN.
        vecs[8]  = '{1'b0, 4'b1011, 4'b0000, 32'h00000000, 4'b0001, 8'h5A, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0010, 4'b0000, 32'h00000000, 4'b0000, 8'h5A, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b0011, 4'b0000, 32'h00000000, 4'b0010, 8'h5A, 2'd1, 1'b1, 1'b0};
        // Owner holds its index while IDLE; q holds.
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 8'h5A, 2'd1, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].req, vecs[i].wr, vecs[i].din);
            tick();
            check($sformatf("vec%0d_gnt", i),   32'(bus.gnt),     32'(vecs[i].gnt));
            check($sformatf("vec%0d_q", i),     32'(bus.q),       32'(vecs[i].q));
            check($sformatf("vec%0d_owner", i), 32'(bus.owner),   32'(vecs[i].owner));
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),    32'(vecs[i].busy));
            check($sformatf("vec%0d_tmo", i),   32'(bus.timeout), 32'(vecs[i].tmo));
        end

        // ---------------- reset mid-OWN ----------------
        do_reset();
        drive(4'b0100, 4'b0000, 32'h0);
        tick();
        check("rst_pre_gnt", 32'(bus.gnt), 32'h4);
        drive(4'b0100, 4'b0100, 32'h00A50000);
        tick();
        check("rst_pre_q", 32'(bus.q), 32'hA5);
        drive(4'b0100, 4'b0000, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        // Asynchronous: values must already be cleared, before any edge.
        check("rst_async_gnt",   32'(bus.gnt),   32'h0);
        check("rst_async_q",     32'(bus.q),     32'h0);
        check("rst_async_busy",  32'(bus.busy),  32'h0);
        check("rst_async_owner", 32'(bus.owner), 32'h0);
        check("rst_async_state", 32'(bus.state), 32'(ST_IDLE));
        tick();
        tick();
        tick();
        check("rst_hold_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b0;
        drive(4'b1010, 4'b0000, 32'h0);
        tick();
        // last reset to 3: requester 1 beats requester 3.
        check("rst_prio_gnt", 32'(bus.gnt), 32'h2);
        drive(4'b0000, 4'b0000, 32'h0);
        tick();

        // ---------------- round-robin order 0,1,2,3,0 ----------------
        do_reset();
        drive(4'b1111, 4'b0000, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            int e;
            e = i % 4;
            check($sformatf("rr%0d_gnt_a", i), 32'(bus.gnt),   32'(1 << e));
            check($sformatf("rr%0d_owner", i), 32'(bus.owner), 32'(e));
            tick();
            check($sformatf("rr%0d_gnt_b", i), 32'(bus.gnt), 32'(1 << e));
            bus.req[e] = 1'b0;
            tick();
            check($sformatf("rr%0d_gap", i),  32'(bus.gnt),  32'h0);
            check($sformatf("rr%0d_busy", i), 32'(bus.busy), 32'h0);
            bus.req[e] = 1'b1;
            if (i < 4) tick();
        end
        drive(4'b0000, 4'b0000, 32'h0);
        tick();
        check("rr_idle_gnt", 32'(bus.gnt), 32'h0);

        // ---------------- watchdog, lone requester 1 ----------------
        // Grant at edge 1; 15 cycles high, revoke edge, REVOKE, IDLE, re-grant: period 17.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0);
        run = 0;
        for (int n = 1; n <= 40; n++) begin
            int ph;
            tick();
            ph = (n - 1) % 17;
            exp_gnt = (ph < 15) ? 2 : 0;
            check($sformatf("wd%0d_gnt", n), 32'(bus.gnt),     32'(exp_gnt));
            check($sformatf("wd%0d_tmo", n), 32'(bus.timeout), 32'(ph == 15));
            if (n <= 17 && bus.gnt[1]) run++;
        end
        check("wd_run_len", 32'(run), 32'(TIMEOUT));
        drive(4'b0000, 4'b0000, 32'h0);
        tick();
        tick();

        // ---------------- watchdog fairness, requesters 1 and 2 ----------------
        do_reset();
        drive(4'b0110, 4'b0000, 32'h0);
        for (int n = 1; n <= 36; n++) begin
            int ph;
            int seg;
            tick();
            ph  = (n - 1) % 17;
            seg = (n - 1) / 17;
            exp_gnt = (ph < 15) ? ((seg % 2 == 0) ? 2 : 4) : 0;
            check($sformatf("fair%0d_gnt", n),   32'(bus.gnt),     32'(exp_gnt));
            check($sformatf("fair%0d_owner", n), 32'(bus.owner),   32'((seg % 2 == 0) ? 1 : 2));
            check($sformatf("fair%0d_tmo", n),   32'(bus.timeout), 32'(ph == 15));
        end
        drive(4'b0000, 4'b0000, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer sharing one DW-bit edge-triggered D register bank among N_REQ requesters. A requester raises req, receives a one-hot grant, and writes the shared register with wr strobes. It keeps ownership until it drops req, or until a hold watchdog revokes the grant. The block sits between the latch/flip-flop storage experiments and any multi-source logic that must time-share one storage register.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, width of the shared register and of each requester data slice
TIMEOUT, 15, maximum consecutive cycles one owner may hold the grant (>=2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
req  input  N_REQ  per-requester request, level held for whole ownership
wr  input  N_REQ  per-requester write strobe, effective only for current owner
din  input  N_REQ*DW  flattened write data, slice i = din[i*DW +: DW]
gnt  output  N_REQ  one-hot grant, registered
q  output  DW  shared register contents
owner  output  clog2(N_REQ)  index of current/last owner
busy  output  1  high while state is OWN
timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Single clock; reset is asynchronous and active-high. While rst=1: state=IDLE, gnt=0, q=0, owner=0, busy=0, timeout=0, hold_cnt=0, last=N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, OWN, REVOKE.
- IDLE:
  - If req != 0, pick the first requester with req set, scanning (last+1) mod N_REQ upward with wrap.
  - At the same edge: gnt<=onehot(pick), owner<=pick, busy<=1, hold_cnt<=0, state<=OWN.
  - Latency: req seen high at edge k gives gnt high after edge k (one cycle).
  - If req == 0, remain in IDLE with gnt=0.
- OWN:
  - Write: if wr[owner]=1 at an edge, q<=din slice owner. wr from non-owners is ignored.
  - Release: if req[owner]=0 at an edge, then gnt<=0, busy<=0, last<=owner, state<=IDLE. A wr[owner] sampled at that same edge is still honoured.
  - Watchdog: if req[owner]=1 and hold_cnt==TIMEOUT-1, then gnt<=0, busy<=0, timeout<=1, last<=owner, state<=REVOKE. A write at this edge is honoured. Maximum OWN duration is exactly TIMEOUT cycles.
  - Otherwise: hold_cnt<=hold_cnt+1, saturating at TIMEOUT-1.
  - req changes of non-owners have no effect while in OWN.
- REVOKE:
  - Lasts one cycle: timeout<=0, state<=IDLE.
  - The revoked requester is last in round-robin order on the next arbitration. If it is the only requester, it is re-granted.
- Hand-over gap: release/revoke edge, then one IDLE cycle (two for REVOKE), then the next grant. gnt is never asserted for two requesters in the same cycle, and is all-zero for at least one cycle between owners.
- owner holds the last owner's index while IDLE.
- q holds its value indefinitely; only an owner write or rst changes it.
- rst mid-ownership: immediate return to reset values, with q cleared.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, OWN=2'd1, REVOKE=2'd2), clog2 helper, default DW/N_REQ/TIMEOUT.
- Sub-module rr_pick: combinational round-robin priority select. Inputs are req and last; outputs are pick index and a valid flag. It is reusable by other arbiters.
- The top level holds the FSM, hold counter, and the DW-bit register (a row of D flip-flops with load enable).

Test Plan:
- Reset: assert rst for 3 cycles mid-OWN with q=8'hA5, then release -> gnt=0, q=8'h00, busy=0, owner=0 immediately on rst rise.
- Single grant/write: req=4'b0100, then wr[2]=1 with slice2=8'h3C one cycle after gnt -> gnt=4'b0100 exactly one cycle after req; q=8'h3C; wr[0]=1 with slice0=8'hFF concurrently is ignored.
- Round-robin: req=4'b1111 held, each owner drops req after 2 OWN cycles then re-raises -> grant order 0,1,2,3,0 with a one-cycle gnt=0 gap between owners.
- Watchdog: req[1] held for 40 cycles, others 0 -> gnt[1] high exactly 15 cycles, timeout pulses 1 cycle, re-grant of 1 after REVOKE+IDLE, pattern repeats.
- Watchdog fairness: req[1] and req[2] both held -> after 1 is revoked, 2 is granted next; after 2 times out, 1 is granted.
- Release with write: owner 3 drops req with wr[3]=1 and slice3=8'h5A on the same edge -> q=8'h5A, gnt=0 next cycle, next arbitration starts from requester 0.
